// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding and default widths
// that instr_ptr, instr_fetch and the decoder agree on.
package fetch_pkg;

  localparam int PTR_WIDTH_DEF   = 8;
  localparam int INSTR_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous show-ahead FIFO. The head word is visible on pop_data whenever
// the FIFO is not empty. Push and pop may happen in the same cycle, even when
// the FIFO is full or empty. Flush empties the FIFO and takes priority over
// push and pop. DEPTH must be a power of two.
module instr_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = store[rd_ptr];

  // Pointer and occupancy bookkeeping; the pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so that a freshly reset head reads as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives the instr_ptr controls, issues reads to a
// fixed-latency instruction memory, tags each read with its address and
// buffers returned words for the decoder. A read is issued only while the
// output FIFO has room for it, counting the reads still in flight.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int PTR_WIDTH   = PTR_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   jump_req,
  input  logic [PTR_WIDTH-1:0]   jump_addr,
  input  logic [PTR_WIDTH-1:0]   ptr_in,
  output logic                   ptr_enable,
  output logic                   ptr_load_enable,
  output logic [PTR_WIDTH-1:0]   ptr_load_val,
  output logic [PTR_WIDTH-1:0]   mem_addr,
  output logic                   mem_rd_en,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PTR_WIDTH-1:0]   instr_addr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  // Width that holds fifo_count + inflight without overflow.
  localparam int SW = $clog2(FIFO_DEPTH + MEM_LATENCY + 1);
  localparam logic [SW-1:0] CREDIT_LIMIT = FIFO_DEPTH[SW-1:0];
  localparam int EW = INSTR_WIDTH + PTR_WIDTH;

  fetch_state_t         state;
  logic [MEM_LATENCY-1:0] pipe_valid;
  logic [PTR_WIDTH-1:0] pipe_addr [MEM_LATENCY];
  logic [SW-1:0]        inflight;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_pop;
  logic [EW-1:0]        fifo_head;
  logic                 issue;
  logic                 jump_active;

  // A redirect outside IDLE kills every outstanding read and the buffered words.
  assign jump_active = jump_req && (state != ST_IDLE);

  // Count the reads still travelling through the memory.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + SW'(pipe_valid[i]);
    end
  end

  // Issue decision: RUN, no redirect, no halt, and a guaranteed FIFO slot.
  always_comb begin
    if ((state == ST_RUN) && !jump_req && !halt && !fifo_full) begin
      issue = ((SW'(fifo_count) + inflight) < CREDIT_LIMIT);
    end else begin
      issue = 1'b0;
    end
  end

  assign mem_rd_en       = issue;
  assign ptr_enable      = issue;
  assign mem_addr        = ptr_in;
  assign ptr_load_enable = jump_req;
  assign ptr_load_val    = jump_req ? jump_addr : '0;
  assign busy            = (state != ST_IDLE);

  assign instr_valid = !fifo_empty;
  assign instr_out   = fifo_empty ? '0 : fifo_head[EW-1:PTR_WIDTH];
  assign instr_addr  = fifo_empty ? '0 : fifo_head[PTR_WIDTH-1:0];
  assign fifo_pop    = instr_valid && instr_ready;

  // Control FSM: IDLE -> RUN on start, RUN -> DRAIN on halt, DRAIN -> IDLE once empty of reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state <= ST_RUN;
        ST_RUN:   if (halt) state <= ST_DRAIN;
        ST_DRAIN: if (inflight == '0) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Valid tags of in-flight reads; cleared on redirect so stale data is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid <= '0;
    end else if (jump_active) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= issue;
      for (int i = 1; i < MEM_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  // Address tags travel alongside the valid bits to label the returned word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_addr[0] <= ptr_in;
      for (int i = 1; i < MEM_LATENCY; i++) pipe_addr[i] <= pipe_addr[i-1];
    end
  end

  instr_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pipe_valid[MEM_LATENCY-1]),
    .push_data ({mem_data, pipe_addr[MEM_LATENCY-1]}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .flush     (jump_active),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
